tt_um_prio_code_decoder: RTL and testbench

//  Inverse of the team's 16-bit priority encoder. Accepts encoded addresses
//  (0x00-0x0F = bit index, NONE_CODE = "no bit set") one strobe at a time and

---
 rtl/tt_um_prio_code_decoder.sv | 137 +++++++++++++
 tb/tb_tt_um_prio_code_decoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_prio_code_decoder.sv
// Rebuilds a 16-bit bitmap from strobed priority-encoder codes (replace or OR-accumulate).
// Optional PRIO_RECHECK_EN adds a re-encoder for readback and a post-decode consistency check.
module tt_um_prio_code_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] NONE_CODE   = 8'hF0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [SYNC_STAGES-1:0] clear_sync;
  logic                   strobe_prev;
  logic                   strobe_edge;
  logic                   clear_s;
  logic [15:0]            bitmap, bitmap_nxt;
  logic                   err, err_nxt;
  logic                   none, none_nxt;
  logic                   ack, ack_nxt;
  logic                   mode;
  logic                   byte_sel;
  logic                   legal_bit;
  logic                   legal_none;
  logic [15:0]            onehot;
  logic [7:0]             byte_out;

  assign mode       = uio_in[2];
  assign byte_sel   = uio_in[3];
  assign clear_s    = clear_sync[SYNC_STAGES-1];
  assign strobe_edge = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;
  assign legal_bit  = (ui_in < 8'd16);
  assign legal_none = (ui_in == NONE_CODE);
  assign onehot     = 16'd1 << ui_in[3:0];

  // Synchronisers and edge detect; prev tracks even during clear so no stale edge survives it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync <= '0;
      clear_sync  <= '0;
      strobe_prev <= 1'b0;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], uio_in[0]};
      clear_sync  <= {clear_sync[SYNC_STAGES-2:0], uio_in[1]};
      strobe_prev <= strobe_sync[SYNC_STAGES-1];
    end
  end

`ifdef PRIO_RECHECK_EN
  logic       chk_pend;
  logic [7:0] chk_code;
  logic [7:0] reenc;

  // MSB wins; an empty bitmap encodes as NONE_CODE
  function automatic logic [7:0] prio_enc(input logic [15:0] v);
    prio_enc = NONE_CODE;
    for (int i = 0; i < 16; i++)
      if (v[i]) prio_enc = 8'(i);
  endfunction

  assign reenc = prio_enc(bitmap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_pend <= 1'b0;
      chk_code <= 8'h00;
    end else begin
      chk_pend <= strobe_edge & ~clear_s & ~mode & (legal_bit | legal_none);
      chk_code <= ui_in;
    end
  end
`endif

  always_comb begin
    bitmap_nxt = bitmap;
    err_nxt    = err;
    none_nxt   = none;
    ack_nxt    = ack;
    if (clear_s) begin
      bitmap_nxt = 16'h0000;
      err_nxt    = 1'b0;
      none_nxt   = 1'b0;
    end else begin
      if (strobe_edge) begin
        ack_nxt = ~ack;
        if (legal_bit) begin
          bitmap_nxt = mode ? (bitmap | onehot) : onehot;
          none_nxt   = 1'b0;
        end else if (legal_none) begin
          if (!mode) bitmap_nxt = 16'h0000;
          none_nxt = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
`ifdef PRIO_RECHECK_EN
      if (chk_pend && (reenc != chk_code)) err_nxt = 1'b1;
`endif
    end
  end

  // Decode stage: state updates at the detect edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap <= 16'h0000;
      err    <= 1'b0;
      none   <= 1'b0;
      ack    <= 1'b0;
    end else begin
      bitmap <= bitmap_nxt;
      err    <= err_nxt;
      none   <= none_nxt;
      ack    <= ack_nxt;
    end
  end

  assign byte_out = byte_sel ? bitmap[15:8] : bitmap[7:0];

`ifdef PRIO_RECHECK_EN
  assign uo_out = uio_in[4] ? reenc : byte_out;
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:5]};
`else
  assign uo_out = byte_out;
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};
`endif

  assign uio_out = {&bitmap, ack, none, err, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_prio_code_decoder.sv
// Directed bench for tt_um_prio_code_decoder; define PRIO_RECHECK_EN to also cover the re-encoder.
module tb_tt_um_prio_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic       strobe = 1'b0, clear = 1'b0, mode = 1'b0, byte_sel = 1'b0, recheck_sel = 1'b0;
  logic [7:0] uio_in;
  logic       exp_ack = 1'b0;
  int         checks = 0;
  int         errors = 0;

  assign uio_in = {3'b000, recheck_sel, byte_sel, mode, clear, strobe};

  always #5 clk = ~clk;

  tt_um_prio_code_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [7:0] code, input logic m);
    ui_in = code; mode = m; strobe = 1'b1;
    tick(4);
    strobe = 1'b0;
    exp_ack = ~exp_ack;
    tick(4);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(4);
    clear = 1'b0; tick(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(2);
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo got %h exp 00", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio got %h exp 00", uio_out); end
    checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL uio_oe got %h exp F0", uio_oe); end
    rst_n = 1'b1; exp_ack = 1'b0; tick(2);
  endtask

  task automatic test_replace_latency();
    ui_in = 8'h0B; mode = 1'b0; strobe = 1'b1;
    tick(2);
    checks++; if (uio_out[6] !== 1'b0) begin errors++; $display("FAIL early_ack got %b exp 0", uio_out[6]); end
    tick(1);
    checks++; if (uio_out[6] !== 1'b1) begin errors++; $display("FAIL latency_ack got %b exp 1", uio_out[6]); end
    tick(2); strobe = 1'b0; exp_ack = 1'b1; tick(4);
    checks++; if (uio_out[6] !== exp_ack) begin errors++; $display("FAIL held_ack got %b exp %b", uio_out[6], exp_ack); end
    byte_sel = 1'b1; #1;
    checks++; if (uo_out !== 8'h08) begin errors++; $display("FAIL rep_hi got %h exp 08", uo_out); end
    byte_sel = 1'b0; #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL rep_lo got %h exp 00", uo_out); end
    checks++; if (uio_out[5:4] !== 2'b00) begin errors++; $display("FAIL rep_flags got %b exp 00", uio_out[5:4]); end
  endtask

  task automatic test_accumulate();
    logic ack0;
    pulse_clear();
    ack0 = uio_out[6];
    send_code(8'h00, 1'b1); send_code(8'h07, 1'b1);
    send_code(8'h0F, 1'b1); send_code(8'h08, 1'b1);
    byte_sel = 1'b0; #1;
    checks++; if (uo_out !== 8'h81) begin errors++; $display("FAIL acc_lo got %h exp 81", uo_out); end
    byte_sel = 1'b1; #1;
    checks++; if (uo_out !== 8'h81) begin errors++; $display("FAIL acc_hi got %h exp 81", uo_out); end
    checks++; if (uio_out[6] !== ack0) begin errors++; $display("FAIL acc_ack got %b exp %b", uio_out[6], ack0); end
    // mode toggling alone must not disturb the bitmap
    mode = 1'b0; tick(3);
    checks++; if (uo_out !== 8'h81) begin errors++; $display("FAIL mode_idle got %h exp 81", uo_out); end
  endtask

  task automatic test_none_code();
    send_code(8'hF0, 1'b1);
    byte_sel = 1'b1; #1;
    checks++; if (uo_out !== 8'h81 || uio_out[5] !== 1'b1) begin errors++; $display("FAIL none_acc got %h/%b exp 81/1", uo_out, uio_out[5]); end
    send_code(8'hF0, 1'b0);
    checks++; if (uo_out !== 8'h00 || uio_out[5] !== 1'b1) begin errors++; $display("FAIL none_rep got %h/%b exp 00/1", uo_out, uio_out[5]); end
    send_code(8'h03, 1'b0);
    byte_sel = 1'b0; #1;
    checks++; if (uo_out !== 8'h08 || uio_out[5] !== 1'b0) begin errors++; $display("FAIL after_none got %h/%b exp 08/0", uo_out, uio_out[5]); end
  endtask

  task automatic test_illegal();
    send_code(8'h10, 1'b0);
    checks++; if (uo_out !== 8'h08 || uio_out[4] !== 1'b1) begin errors++; $display("FAIL ill_10 got %h/%b exp 08/1", uo_out, uio_out[4]); end
    send_code(8'hF1, 1'b1);
    checks++; if (uio_out[4] !== 1'b1 || uio_out[6] !== exp_ack) begin errors++; $display("FAIL ill_f1 got err %b ack %b exp 1 %b", uio_out[4], uio_out[6], exp_ack); end
    checks++; if (uo_out !== 8'h08) begin errors++; $display("FAIL ill_keep got %h exp 08", uo_out); end
    send_code(8'h02, 1'b0);
    checks++; if (uio_out[4] !== 1'b1 || uo_out !== 8'h04) begin errors++; $display("FAIL err_sticky got %b/%h exp 1/04", uio_out[4], uo_out); end
    pulse_clear();
    checks++; if (uio_out[4] !== 1'b0 || uo_out !== 8'h00) begin errors++; $display("FAIL clr got %b/%h exp 0/00", uio_out[4], uo_out); end
  endtask

  task automatic test_full_and_clear_drop();
    for (int i = 0; i < 16; i++) send_code(8'(i), 1'b1);
    checks++; if (uio_out[7] !== 1'b1) begin errors++; $display("FAIL full got %b exp 1", uio_out[7]); end
    byte_sel = 1'b0; #1;
    checks++; if (uo_out !== 8'hFF) begin errors++; $display("FAIL full_lo got %h exp FF", uo_out); end
    byte_sel = 1'b1; #1;
    checks++; if (uo_out !== 8'hFF) begin errors++; $display("FAIL full_hi got %h exp FF", uo_out); end
    ui_in = 8'h05; mode = 1'b0; strobe = 1'b1; clear = 1'b1;
    tick(4);
    checks++; if (uo_out !== 8'h00 || uio_out[7] !== 1'b0) begin errors++; $display("FAIL clr_drop got %h/%b exp 00/0", uo_out, uio_out[7]); end
    checks++; if (uio_out[6] !== exp_ack) begin errors++; $display("FAIL clr_ack got %b exp %b", uio_out[6], exp_ack); end
    clear = 1'b0; tick(4);
    byte_sel = 1'b0; #1;
    checks++; if (uio_out[6] !== exp_ack || uo_out !== 8'h00) begin errors++; $display("FAIL stale_edge got %b/%h exp %b/00", uio_out[6], uo_out, exp_ack); end
    strobe = 1'b0; tick(4);
  endtask

`ifdef PRIO_RECHECK_EN
  task automatic test_recheck();
    pulse_clear();
    send_code(8'h02, 1'b1); send_code(8'h09, 1'b1);
    recheck_sel = 1'b1; #1;
    checks++; if (uo_out !== 8'h09) begin errors++; $display("FAIL reenc got %h exp 09", uo_out); end
    send_code(8'h0C, 1'b0);
    checks++; if (uo_out !== 8'h0C || uio_out[4] !== 1'b0) begin errors++; $display("FAIL recheck_rep got %h/%b exp 0C/0", uo_out, uio_out[4]); end
    pulse_clear();
    checks++; if (uo_out !== 8'hF0) begin errors++; $display("FAIL reenc_empty got %h exp F0", uo_out); end
    recheck_sel = 1'b0; #1;
  endtask
`endif

  task automatic test_mid_reset();
    send_code(8'h06, 1'b0);
    ui_in = 8'h01; mode = 1'b1; strobe = 1'b1;
    tick(1);
    rst_n = 1'b0; #2;
    checks++; if (uo_out !== 8'h00 || uio_out !== 8'h00) begin errors++; $display("FAIL mid_rst got %h/%h exp 00/00", uo_out, uio_out); end
    strobe = 1'b0; tick(2);
    rst_n = 1'b1; exp_ack = 1'b0; tick(5);
    checks++; if (uo_out !== 8'h00 || uio_out !== 8'h00) begin errors++; $display("FAIL lost_strobe got %h/%h exp 00/00", uo_out, uio_out); end
  endtask

  initial begin
    test_reset();
    test_replace_latency();
    test_accumulate();
    test_none_code();
    test_illegal();
    test_full_and_clear_drop();
`ifdef PRIO_RECHECK_EN
    test_recheck();
`endif
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
